// File: rtl/ex_stage_reg_if.sv
// Bundle of decode/ALU inputs and registered execute-stage outputs for ex_stage_reg.
// The master side drives decode/ALU fields; the slave side is the pipeline register.
interface ex_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 30,
    parameter int unsigned EXP_W  = 3,
    parameter int unsigned CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              cnt_clr;
    logic [PC_W-1:0]   id_pc;
    logic              id_en;
    logic [1:0]        id_mem_op;
    logic [DATA_W-1:0] id_mem_wr_data;
    logic [4:0]        id_dst_addr;
    logic              id_gpr_we_;
    logic [EXP_W-1:0]  id_exp_code;
    logic [DATA_W-1:0] alu_out;
    logic              alu_of;

    logic [DATA_W-1:0] fwd_data;
    logic [PC_W-1:0]   ex_pc;
    logic              ex_en;
    logic [1:0]        ex_mem_op;
    logic [DATA_W-1:0] ex_mem_wr_data;
    logic [4:0]        ex_dst_addr;
    logic              ex_gpr_we_;
    logic [EXP_W-1:0]  ex_exp_code;
    logic [DATA_W-1:0] ex_out;
    logic [CNT_W-1:0]  ovf_cnt;

    modport master (
        output stall, flush, cnt_clr, id_pc, id_en, id_mem_op, id_mem_wr_data, id_dst_addr,
               id_gpr_we_, id_exp_code, alu_out, alu_of,
        input  fwd_data, ex_pc, ex_en, ex_mem_op, ex_mem_wr_data, ex_dst_addr, ex_gpr_we_,
               ex_exp_code, ex_out, ovf_cnt
    );

    modport slave (
        input  stall, flush, cnt_clr, id_pc, id_en, id_mem_op, id_mem_wr_data, id_dst_addr,
               id_gpr_we_, id_exp_code, alu_out, alu_of,
        output fwd_data, ex_pc, ex_en, ex_mem_op, ex_mem_wr_data, ex_dst_addr, ex_gpr_we_,
               ex_exp_code, ex_out, ovf_cnt
    );
endinterface

// File: rtl/ex_stage_reg.sv
// Execute -> memory pipeline register: captures ALU result and control, turns ALU overflow
// into a registered exception, forwards alu_out to decode and counts overflow events.
module ex_stage_reg #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PC_W         = 30,
    parameter int unsigned EXP_W        = 3,
    parameter int unsigned EXP_OVERFLOW = 3,
    parameter int unsigned CNT_W        = 16
) (
    input logic            clk,
    input logic            reset_,
    ex_stage_reg_if.slave  bus
);
    localparam logic [EXP_W-1:0] ExpOvf = EXP_W'(EXP_OVERFLOW);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              en_q, en_d;
    logic [1:0]        mem_op_q, mem_op_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [4:0]        dst_q, dst_d;
    logic              we_n_q, we_n_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic ovf;
    logic load_normal;

    // An upstream exception masks overflow, so ovf only fires on otherwise clean instructions.
    assign ovf         = bus.id_en & bus.alu_of & (bus.id_exp_code == '0);
    assign load_normal = ~bus.stall & ~bus.flush;

    always_comb begin
        pc_d      = pc_q;
        en_d      = en_q;
        mem_op_d  = mem_op_q;
        wr_data_d = wr_data_q;
        dst_d     = dst_q;
        we_n_d    = we_n_q;
        exp_d     = exp_q;
        out_d     = out_q;
        cnt_d     = cnt_q;

        if (!bus.stall) begin
            pc_d      = bus.id_pc;
            wr_data_d = bus.id_mem_wr_data;
            dst_d     = bus.id_dst_addr;
            out_d     = bus.alu_out;
            if (bus.flush) begin
                en_d     = 1'b0;
                mem_op_d = 2'd0;
                we_n_d   = 1'b1;
                exp_d    = '0;
            end else begin
                en_d     = bus.id_en;
                mem_op_d = bus.id_mem_op;
                we_n_d   = bus.id_gpr_we_;
                exp_d    = bus.id_exp_code;
                if (ovf) begin
                    // Kill side effects; the faulting result is still captured.
                    exp_d    = ExpOvf;
                    mem_op_d = 2'd0;
                    we_n_d   = 1'b1;
                end
            end
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (load_normal && ovf && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pc_q      <= '0;
            en_q      <= 1'b0;
            mem_op_q  <= 2'd0;
            wr_data_q <= '0;
            dst_q     <= '0;
            we_n_q    <= 1'b1;
            exp_q     <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            en_q      <= en_d;
            mem_op_q  <= mem_op_d;
            wr_data_q <= wr_data_d;
            dst_q     <= dst_d;
            we_n_q    <= we_n_d;
            exp_q     <= exp_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.fwd_data       = bus.alu_out;
    assign bus.ex_pc          = pc_q;
    assign bus.ex_en          = en_q;
    assign bus.ex_mem_op      = mem_op_q;
    assign bus.ex_mem_wr_data = wr_data_q;
    assign bus.ex_dst_addr    = dst_q;
    assign bus.ex_gpr_we_     = we_n_q;
    assign bus.ex_exp_code    = exp_q;
    assign bus.ex_out         = out_q;
    assign bus.ovf_cnt        = cnt_q;
endmodule

// File: doc/ex_stage_reg.md
Name: ex_stage_reg

Overview:
Pipeline register between the ALU (execute stage) and the memory-access stage. It captures the ALU result and the instruction control fields from decode. Signed-arithmetic overflow reported by the ALU becomes a registered exception that kills the instruction's side effects. It also provides a combinational forwarding path to decode and a saturating overflow-event counter for debug/performance readout.

Parameters:
DATA_W, 32, width of the word data bus (ALU operands and result)
PC_W, 30, width of the word-address program counter
EXP_W, 3, width of the exception code; the value 0 means no exception
EXP_OVERFLOW, 3, exception code raised on an ALU overflow
CNT_W, 16, width of the overflow event counter

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset_  in  1  asynchronous, active-low reset
stall  in  1  1 = hold every register at its current value
flush  in  1  1 = insert a bubble (ignored while stall=1)
cnt_clr  in  1  synchronous clear of ovf_cnt
id_pc  in  PC_W  PC of the instruction in execute
id_en  in  1  instruction in execute is valid
id_mem_op  in  2  memory operation: 0 NOP, 1 LOAD, 2 STORE, 3 reserved (treated as NOP downstream)
id_mem_wr_data  in  DATA_W  store data
id_dst_addr  in  5  destination GPR index
id_gpr_we_  in  1  GPR write enable, active-low
id_exp_code  in  EXP_W  exception already detected upstream
alu_out  in  DATA_W  ALU result
alu_of  in  1  ALU signed overflow flag
fwd_data  out  DATA_W  combinational copy of alu_out for bypass to decode
ex_pc  out  PC_W  registered id_pc
ex_en  out  1  registered valid
ex_mem_op  out  2  registered memory operation
ex_mem_wr_data  out  DATA_W  registered store data
ex_dst_addr  out  5  registered destination index
ex_gpr_we_  out  1  registered GPR write enable, active-low
ex_exp_code  out  EXP_W  registered exception code
ex_out  out  DATA_W  registered ALU result
ovf_cnt  out  CNT_W  count of overflow exceptions registered

Behaviour:
- Reset (reset_=0, asynchronous, effective immediately):
  - ex_pc, ex_mem_wr_data, ex_out, ex_dst_addr, ex_exp_code = 0
  - ex_en = 0, ex_mem_op = 0, ex_gpr_we_ = 1, ovf_cnt = 0
  - Reset asserted mid-operation discards the in-flight instruction.
- Latency: one cycle from the id_*/alu_* inputs to the ex_* outputs. fwd_data has zero latency and ignores stall, flush and reset.
- Priority at each rising edge: stall > flush > normal load.
  - stall=1: all ex_* outputs hold.
  - stall=0, flush=1: ex_en=0, ex_mem_op=0, ex_gpr_we_=1, ex_exp_code=0. ex_pc, ex_out, ex_mem_wr_data and ex_dst_addr load normally; their values are don't-care.
  - stall=0, flush=0: all fields load, then the exception rules below apply.
- Overflow detection: ovf = id_en & alu_of & (id_exp_code==0).
- Exception rules:
  - id_exp_code!=0: ex_exp_code=id_exp_code. An upstream exception beats overflow.
  - Else if ovf: ex_exp_code=EXP_OVERFLOW, ex_mem_op=0, ex_gpr_we_=1. ex_out still captures alu_out.
  - Else: ex_exp_code=0 and the control fields pass through unchanged.
- id_en=0: fields load, ex_en=0, and no exception is raised regardless of alu_of.
- ovf_cnt:
  - Increments by 1 on an edge where the register loads normally (stall=0, flush=0) with ovf=1.
  - Saturates at 2^CNT_W-1; it does not wrap.
  - cnt_clr=1 forces 0 and beats a simultaneous increment.
  - Unaffected by stall otherwise.
- Data fields are transported unmodified. No width conversion; no sign extension.

Test Plan:
- Reset: assert reset_=0 mid-stream with ex_en=1 -> all outputs reach their reset values immediately without waiting for a clock edge; first edge after release loads normally.
- Normal load: id_en=1, alu_out=0x0000_0005, alu_of=0, id_gpr_we_=0, id_dst_addr=7 -> next cycle ex_out=5, ex_dst_addr=7, ex_gpr_we_=0, ex_exp_code=0; fwd_data=5 in the same cycle.
- Overflow: alu_out=0x8000_0000, alu_of=1, id_mem_op=2, id_gpr_we_=0 -> ex_exp_code=3, ex_mem_op=0, ex_gpr_we_=1, ex_out=0x8000_0000, ovf_cnt +1. Repeat with id_exp_code=1 -> ex_exp_code=1, ovf_cnt unchanged.
- Stall/flush: stall=1 with flush=1 for 3 cycles -> all outputs frozen. Then stall=0, flush=1 -> ex_en=0, ex_gpr_we_=1, ex_mem_op=0.
- Counter: preload via 65535 overflow instructions (CNT_W=16) -> ovf_cnt=0xFFFF and stays there on the next overflow. cnt_clr=1 together with an overflow -> ovf_cnt=0.
- id_en=0 with alu_of=1 -> ex_en=0, ex_exp_code=0, ovf_cnt unchanged.
